// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared BedRock LCE request types and CCE request-decode helpers
package bp_me_pkg;

  localparam int paddr_width_gp  = 40;
  localparam int lce_id_width_gp = 4;
  localparam int cce_id_width_gp = 4;
  localparam int lce_assoc_gp    = 8;
  localparam int lg_lce_assoc_gp = $clog2(lce_assoc_gp);
  localparam int dword_width_gp  = 64;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  // Encodings 13..15 are undefined and must be rejected by the receiver
  typedef enum logic [3:0] {
    e_bedrock_req_rd      = 4'd0,
    e_bedrock_req_wr      = 4'd1,
    e_bedrock_req_uc_rd   = 4'd2,
    e_bedrock_req_uc_wr   = 4'd3,
    e_bedrock_req_amoswap = 4'd4,
    e_bedrock_req_amoadd  = 4'd5,
    e_bedrock_req_amoxor  = 4'd6,
    e_bedrock_req_amoand  = 4'd7,
    e_bedrock_req_amoor   = 4'd8,
    e_bedrock_req_amomin  = 4'd9,
    e_bedrock_req_amomax  = 4'd10,
    e_bedrock_req_amominu = 4'd11,
    e_bedrock_req_amomaxu = 4'd12
  } bp_bedrock_req_type_e;

  typedef enum logic [1:0] {
    e_cls_cached = 2'd0,
    e_cls_uc_rd  = 2'd1,
    e_cls_uc_wr  = 2'd2,
    e_cls_amo    = 2'd3
  } bp_cce_req_class_e;

  typedef enum logic {
    e_cce_mode_normal   = 1'b0,
    e_cce_mode_uncached = 1'b1
  } bp_cce_mode_e;

  typedef struct packed {
    logic [cce_id_width_gp-1:0] dst_id;
    logic [lce_id_width_gp-1:0] src_id;
    logic                       non_exclusive;
    logic [lg_lce_assoc_gp-1:0] lru_way_id;
    logic                       amo_no_return;
  } bp_bedrock_lce_req_payload_s;

  typedef struct packed {
    bp_bedrock_req_type_e        msg_type;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_msg_size_e        size;
    bp_bedrock_lce_req_payload_s payload;
  } bp_bedrock_lce_req_hdr_s;

  typedef struct packed {
    bp_bedrock_lce_req_hdr_s    header;
    logic [dword_width_gp-1:0]  data;
  } bp_bedrock_lce_req_msg_s;

  localparam int lce_req_msg_width_gp = $bits(bp_bedrock_lce_req_msg_s);

  // Cached transfers always move one whole block: size code is log2(bytes per block)
  function automatic bp_bedrock_msg_size_e bp_cached_size(input int block_width);
    return bp_bedrock_msg_size_e'(3'($clog2(block_width / 8)));
  endfunction

endpackage

// File: rtl/bp_cce_req_buf.sv
// rtl/bp_cce_req_buf.sv - two-entry ready->valid message FIFO, no bypass
module bp_cce_req_buf
  #(parameter int width_p = 8)
  (input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               full_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i);

  logic [1:0][width_p-1:0] r_mem;
  logic                    r_rd_ptr;
  logic                    r_wr_ptr;
  logic [1:0]              r_count;
  logic                    w_enq;
  logic                    w_deq;

  assign full_o = (r_count == 2'd2);
  assign v_o    = (r_count != 2'd0);
  assign data_o = r_mem[r_rd_ptr];
  assign w_enq  = v_i & ~full_o;
  assign w_deq  = yumi_i & v_o;

  // Entry storage, pointers and occupancy; entries cleared so the head never reads X
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_mem    <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deq) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bp_cce_lce_req_decode.sv
// rtl/bp_cce_lce_req_decode.sv - CCE receiver: buffers, validates and decodes LCE requests with credit tracking
module bp_cce_lce_req_decode
  import bp_me_pkg::*;
  #(parameter int block_width_p = 512,
    parameter int credits_p     = 2,
    localparam int lce_req_msg_width_lp = lce_req_msg_width_gp,
    localparam int inflight_width_lp    = $clog2(credits_p + 1))
  (input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic [cce_id_width_gp-1:0]      cce_id_i,
   input  logic                            cce_mode_i,
   input  logic [lce_req_msg_width_lp-1:0] lce_req_i,
   input  logic                            lce_req_v_i,
   output logic                            lce_req_ready_o,
   output logic                            req_v_o,
   input  logic                            req_yumi_i,
   output logic [lce_id_width_gp-1:0]      req_src_lce_o,
   output logic [paddr_width_gp-1:0]       req_addr_o,
   output logic [2:0]                      req_size_o,
   output logic [1:0]                      req_class_o,
   output logic                            req_write_o,
   output logic                            req_non_excl_o,
   output logic [lg_lce_assoc_gp-1:0]      req_lru_way_o,
   output logic [3:0]                      req_amo_op_o,
   output logic                            req_amo_no_return_o,
   output logic [dword_width_gp-1:0]       req_data_o,
   input  logic                            complete_i,
   output logic                            error_o,
   output logic [inflight_width_lp-1:0]    inflight_o);

  localparam logic [1:0] e_reset = 2'd0;
  localparam logic [1:0] e_ready = 2'd1;
  localparam logic [1:0] e_error = 2'd2;

  localparam bp_bedrock_msg_size_e cached_size_lp = bp_cached_size(block_width_p);
  localparam logic [inflight_width_lp-1:0] credit_lim_lp = inflight_width_lp'(credits_p);

  logic [1:0]                      r_state;
  logic [1:0]                      w_state_next;
  logic [inflight_width_lp-1:0]    r_inflight;
  logic                            r_underflow;
  logic                            w_buf_full;
  logic                            w_buf_v;
  logic                            w_buf_yumi;
  logic [lce_req_msg_width_lp-1:0] w_head_raw;
  bp_bedrock_lce_req_msg_s         w_head;
  bp_bedrock_req_type_e            w_type;
  logic                            w_is_cached;
  logic                            w_is_uc_rd;
  logic                            w_is_uc_wr;
  logic                            w_is_amo;
  logic                            w_illegal;
  logic                            w_yumi;

  bp_cce_req_buf #(.width_p(lce_req_msg_width_lp)) u_buf
    (.clk_i     (clk_i),
     .reset_n_i (reset_n_i),
     .data_i    (lce_req_i),
     .v_i       (lce_req_v_i & lce_req_ready_o),
     .full_o    (w_buf_full),
     .v_o       (w_buf_v),
     .data_o    (w_head_raw),
     .yumi_i    (w_buf_yumi));

  assign lce_req_ready_o = (r_state != e_reset) & ~w_buf_full;

  assign w_head      = w_head_raw;
  assign w_type      = w_head.header.msg_type;
  assign w_is_cached = (w_type == e_bedrock_req_rd) | (w_type == e_bedrock_req_wr);
  assign w_is_uc_rd  = (w_type == e_bedrock_req_uc_rd);
  assign w_is_uc_wr  = (w_type == e_bedrock_req_uc_wr);
  assign w_is_amo    = (w_type >= e_bedrock_req_amoswap) & (w_type <= e_bedrock_req_amomaxu);

  assign w_illegal = (w_head.header.payload.dst_id != cce_id_i)
                   | (w_is_cached & (w_head.header.size != cached_size_lp))
                   | ((w_is_cached | w_is_amo) & (cce_mode_i == e_cce_mode_uncached))
                   | ~(w_is_cached | w_is_uc_rd | w_is_uc_wr | w_is_amo);

  // A legal head is offered only while a credit is free; a dropped head leaves via e_error
  assign req_v_o    = (r_state == e_ready) & w_buf_v & ~w_illegal & (r_inflight != credit_lim_lp);
  assign w_yumi     = req_yumi_i & req_v_o;
  assign w_buf_yumi = w_yumi | (r_state == e_error);

  assign error_o    = (r_state == e_error) | r_underflow;
  assign inflight_o = r_inflight;

  assign req_src_lce_o       = w_head.header.payload.src_id;
  assign req_addr_o          = w_head.header.addr;
  assign req_size_o          = w_head.header.size;
  assign req_write_o         = (w_type == e_bedrock_req_wr) | w_is_uc_wr;
  assign req_non_excl_o      = (w_type == e_bedrock_req_rd) & w_head.header.payload.non_exclusive;
  assign req_lru_way_o       = w_head.header.payload.lru_way_id;
  assign req_amo_op_o        = w_type;
  assign req_amo_no_return_o = w_head.header.payload.amo_no_return;
  assign req_data_o          = w_head.data;

  // Request class from message type; undefined types never reach req_v_o
  always_comb begin
    req_class_o = e_cls_cached;
    if (w_is_uc_rd)      req_class_o = e_cls_uc_rd;
    else if (w_is_uc_wr) req_class_o = e_cls_uc_wr;
    else if (w_is_amo)   req_class_o = e_cls_amo;
  end

  // Next state: leave reset on the first edge, detour one cycle through e_error on a bad head
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      e_reset: w_state_next = e_ready;
      e_ready: if (w_buf_v & w_illegal) w_state_next = e_error;
      e_error: w_state_next = e_ready;
      default: w_state_next = e_reset;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= e_reset;
    else            r_state <= w_state_next;
  end

  // Credit counter: yumi takes a credit, complete returns one; a return at zero is flagged
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_inflight  <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= 1'b0;
      if (w_yumi & ~complete_i) begin
        r_inflight <= r_inflight + inflight_width_lp'(1);
      end else if (complete_i & ~w_yumi) begin
        if (r_inflight == '0) r_underflow <= 1'b1;
        else                  r_inflight  <= r_inflight - inflight_width_lp'(1);
      end
    end
  end

endmodule
